// File: rtl/pid_mult_sequencer.sv
// pid_mult_sequencer: sequences the P, I and D products of a discrete PID
// controller through one shared external multiplier. A start strobe in IDLE
// runs PREP -> MP -> MI -> MD and returns to IDLE, updating u with a one-cycle
// done pulse. All additions saturate to the signed W-bit range.
module pid_mult_sequencer #(
  parameter int W = 12
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                start,
  input  logic                clr_int,
  input  logic signed [W-1:0] e,
  input  logic signed [W-1:0] kp,
  input  logic signed [W-1:0] ki,
  input  logic signed [W-1:0] kd,
  output logic signed [W-1:0] mul_a,
  output logic signed [W-1:0] mul_b,
  input  logic signed [W-1:0] mul_p,
  output logic signed [W-1:0] u,
  output logic                done,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_MP   = 3'd2,
    S_MI   = 3'd3,
    S_MD   = 3'd4
  } state_t;

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  // Clamp a W+1-bit signed intermediate to the W-bit range; overflow shows up
  // as the two top bits disagreeing.
  function automatic logic signed [W-1:0] sat_ext(input logic signed [W:0] s);
    if (s[W] != s[W-1]) begin
      return s[W] ? SAT_MIN : SAT_MAX;
    end
    return s[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    return sat_ext(s);
  endfunction

  function automatic logic signed [W-1:0] sat_sub(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = {a[W-1], a} - {b[W-1], b};
    return sat_ext(s);
  endfunction

  state_t              r_state;
  state_t              w_state_next;
  logic signed [W-1:0] r_e_reg;
  logic signed [W-1:0] r_integ;
  logic signed [W-1:0] r_e_prev;
  logic signed [W-1:0] r_diff;
  logic signed [W-1:0] r_acc;
  logic signed [W-1:0] r_u;
  logic                r_done;

  // State register; reset may arrive at any point in the sequence.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and multiplier operand steering.
  always_comb begin
    w_state_next = S_IDLE;
    mul_a        = '0;
    mul_b        = '0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy         = 1'b0;
        w_state_next = start ? S_PREP : S_IDLE;
      end
      S_PREP: w_state_next = S_MP;
      S_MP: begin
        mul_a        = r_e_reg;
        mul_b        = kp;
        w_state_next = S_MI;
      end
      S_MI: begin
        mul_a        = r_integ;
        mul_b        = ki;
        w_state_next = S_MD;
      end
      S_MD: begin
        mul_a        = r_diff;
        mul_b        = kd;
        w_state_next = S_IDLE;
      end
      default: begin
        // Unused encodings recover to IDLE without touching the datapath.
        busy         = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: sample capture, integrator/difference update and accumulation.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_e_reg  <= '0;
      r_integ  <= '0;
      r_e_prev <= '0;
      r_diff   <= '0;
      r_acc    <= '0;
      r_u      <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_MD);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_e_reg <= e;
          end else if (clr_int) begin
            r_integ  <= '0;
            r_e_prev <= '0;
          end
        end
        S_PREP: begin
          r_integ  <= sat_add(r_integ, r_e_reg);
          r_diff   <= sat_sub(r_e_reg, r_e_prev);
          r_e_prev <= r_e_reg;
          r_acc    <= '0;
        end
        S_MP:    r_acc <= sat_add(r_acc, mul_p);
        S_MI:    r_acc <= sat_add(r_acc, mul_p);
        S_MD:    r_u   <= sat_add(r_acc, mul_p);
        default: ;
      endcase
    end
  end

  assign u    = r_u;
  assign done = r_done;

endmodule

// File: doc/pid_mult_sequencer.md
# pid_mult_sequencer

Time-shares one `Multiplicador` instance between the proportional, integral and derivative terms of the discrete PID controller. One `start` strobe per sample triggers a fixed five-cycle sequence:
- update the integral and difference state;
- multiply each term by its gain on the shared multiplier;
- accumulate with saturation;
- present the control output `u` with a one-cycle `done` pulse.

It sits between the sample-rate timing logic and the DAC/output stage. It replaces three parallel multipliers such as the one in the proportional path.

## Interface
- `W`, default 12: data width. All data ports are W-bit signed two's complement.
- `CLK` input 1: system clock. All state changes on the rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `start` input 1: sample strobe. Sampled only in IDLE.
- `clr_int` input 1: clears the integrator and `e_prev`. Honoured only in IDLE when `start`=0.
- `e` input W: error sample, captured on the accepted `start` edge.
- `kp`, `ki`, `kd` input W each: gains. Must be held stable while `busy`=1.
- `mul_a` output W: operand A to the shared multiplier.
- `mul_b` output W: operand B to the shared multiplier.
- `mul_p` input W: multiplier product. Combinational from `mul_a`/`mul_b`; already scaled to W bits by the multiplier.
- `u` output W: registered control output. Holds its value between samples.
- `done` output 1: one-cycle pulse when `u` updates.
- `busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, PREP, MP, MI, MD. Encoding is free. Unreachable encodings return to IDLE.
- IDLE
  - `start`=1: capture `e` into `e_reg`, go to PREP.
  - `start`=0 and `clr_int`=1: `integ` <= 0 and `e_prev` <= 0.
  - Otherwise hold.
- PREP
  - `integ` <= sat(`integ` + `e_reg`).
  - `diff` <= sat(`e_reg` - `e_prev`).
  - `e_prev` <= `e_reg`; `acc` <= 0.
  - Go to MP.
- MP: drive `mul_a`=`e_reg`, `mul_b`=`kp`. `acc` <= sat(`acc` + `mul_p`). Go to MI.
- MI: drive `mul_a`=`integ`, `mul_b`=`ki`. `acc` <= sat(`acc` + `mul_p`). Go to MD.
- MD: drive `mul_a`=`diff`, `mul_b`=`kd`. `u` <= sat(`acc` + `mul_p`); `done` <= 1. Go to IDLE.
- In IDLE and PREP, `mul_a` and `mul_b` are 0.
- sat(): the W+1-bit signed result is clamped to [-2^(W-1), 2^(W-1)-1], i.e. [-2048, 2047] for W=12. No wrap-around is permitted anywhere.
- `start` while `busy`=1 is ignored: no queueing, no restart. `clr_int` while `busy`=1 is ignored.

## Timing
- Reset asserted (low), at any time including mid-sequence:
  - state = IDLE;
  - `u`, `done`, `integ`, `e_prev`, `diff`, `acc`, `e_reg` = 0;
  - `mul_a`, `mul_b` = 0; `busy` = 0.
- Reset deasserted: first `start` is accepted on the next rising edge.
- Latency: `start` accepted at edge N.
  - `busy`=1 from after edge N until after edge N+4.
  - `u` and `done` update at edge N+4.
  - `done` is high for exactly the cycle between edges N+4 and N+5.
- Minimum sample spacing is 5 cycles. A `start` coincident with `done`=1 (state IDLE) is accepted, giving back-to-back samples.
- `mul_p` is sampled in the same cycle its operands are driven. The multiplier path must close in one `CLK` period.
- `u` never changes except at the MD→IDLE edge or on reset.

## Test plan
Directed tests use an ideal bench multiplier, `mul_p` = sat(`mul_a`*`mul_b`), W=12.
- Reset, then `kp`=2, `ki`=1, `kd`=3, `e`=10, `start` pulse → `done` at start edge+4, `u`=20+10+30=60.
- Repeat `e`=10 → `integ`=20, `diff`=0 → `u`=40. Then `e`=4 → `integ`=24, `diff`=-6 → `u`=8+24-18=14.
- `kp`=1000, `ki`=`kd`=0, `e`=10 → `u`=2047. With `e`=-10 → `u`=-2048. No wrap.
- `start` asserted continuously for 12 cycles → exactly two `done` pulses, 5 cycles apart. `start` inside a busy window produces no extra sample.
- `clr_int`=1 in IDLE after the integral builds up, then `e`=5, `kp`=0, `ki`=1, `kd`=0 → `u`=5. `clr_int` pulsed while busy → no effect.
- Reset asserted in state MI → all outputs 0 immediately with no `done`. After release, `e`=10, `kp`=1, `ki`=`kd`=0 → `u`=10.
